// File: rtl/comp_pkg.sv
// ============================================================================
//  Module      : comp_pkg
//  Description : Shared types for the iterative magnitude comparator:
//                FSM state encoding, result encoding and result classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package comp_pkg;

    // Controller states of the iterative comparator
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Encoded outcome of one compare
    typedef enum logic [1:0] {
        RES_EQ = 2'd0,
        RES_GT = 2'd1,
        RES_LT = 2'd2
    } result_t;

    // Equality dominates; otherwise the lesser flag picks LT vs GT
    function automatic result_t classify(input logic is_zero, input logic is_less);
        if (is_zero) begin
            return RES_EQ;
        end else if (is_less) begin
            return RES_LT;
        end else begin
            return RES_GT;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/chunk_subtractor.sv
// ============================================================================
//  Module      : chunk_subtractor
//  Description : Combinational CHUNK-bit ripple-borrow subtractor (a - b - bin).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chunk_subtractor #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             borrow_i,
    output logic [CHUNK-1:0] diff_o,
    output logic             borrow_o
);

    // w_brw[k] is the borrow flowing into bit k
    logic [CHUNK:0] w_brw;

    assign w_brw[0] = borrow_i;

    // One full-subtractor cell per bit, borrow rippling upward
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
        assign diff_o[gi]  = a_i[gi] ^ b_i[gi] ^ w_brw[gi];
        assign w_brw[gi+1] = (~a_i[gi] & b_i[gi]) | (~(a_i[gi] ^ b_i[gi]) & w_brw[gi]);
    end

    assign borrow_o = w_brw[CHUNK];

endmodule

`default_nettype wire

// File: rtl/iter_comparator.sv
// ============================================================================
//  Module      : iter_comparator
//  Description : Iterative signed/unsigned magnitude comparator. Subtracts
//                A-B CHUNK bits per cycle, LSB first, and derives
//                equal/greater/lesser from the accumulated zero flag, the
//                final borrow and the top-chunk sign/overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_comparator
    import comp_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int CHUNK = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             clear_i,
    output logic             ready_o,
    output logic             done_o,
    output logic             equal_o,
    output logic             greater_o,
    output logic             lesser_o
);

    localparam int             N      = WIDTH / CHUNK;
    localparam int             CW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  C_LAST = CW'(N - 1);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [WIDTH-1:0]  r_a_sh;
    logic [WIDTH-1:0]  r_b_sh;
    logic              r_signed;
    logic              r_borrow;
    logic              r_zero;
    logic [CW-1:0]     r_cnt;
    logic              r_equal;
    logic              r_greater;
    logic              r_lesser;

    logic              w_accept;
    logic              w_last;
    logic [CHUNK-1:0]  w_a_chunk;
    logic [CHUNK-1:0]  w_b_chunk;
    logic [CHUNK-1:0]  w_diff;
    logic              w_borrow_out;
    logic              w_chunk_zero;
    logic              w_overflow;
    logic              w_less;
    result_t           w_result;

    // A request is taken whenever we are not mid-operation and not aborting
    assign w_accept  = start_i & ~clear_i & (r_state != BUSY);
    assign w_last    = (r_state == BUSY) && (r_cnt == C_LAST);

    assign w_a_chunk = r_a_sh[CHUNK-1:0];
    assign w_b_chunk = r_b_sh[CHUNK-1:0];

    chunk_subtractor #(
        .CHUNK (CHUNK)
    ) u_sub (
        .a_i      (w_a_chunk),
        .b_i      (w_b_chunk),
        .borrow_i (r_borrow),
        .diff_o   (w_diff),
        .borrow_o (w_borrow_out)
    );

    // On the final chunk the operand MSBs sit at the top of the low chunk,
    // so the signed overflow term can be formed without extra storage.
    assign w_chunk_zero = (w_diff == '0);
    assign w_overflow   = (w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1])
                        & (w_a_chunk[CHUNK-1] ^ w_diff[CHUNK-1]);
    assign w_less       = r_signed ? (w_diff[CHUNK-1] ^ w_overflow) : w_borrow_out;
    assign w_result     = classify(r_zero & w_chunk_zero, w_less);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = BUSY;
            BUSY:    if (w_last)   w_state_nxt = DONE;
            DONE:    w_state_nxt = w_accept ? BUSY : IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (clear_i) begin
            w_state_nxt = IDLE;
        end
    end

    // Operand shifting, borrow/zero accumulation and result capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_signed  <= 1'b0;
            r_borrow  <= 1'b0;
            r_zero    <= 1'b0;
            r_cnt     <= '0;
            r_equal   <= 1'b0;
            r_greater <= 1'b0;
            r_lesser  <= 1'b0;
        end else if (clear_i) begin
            r_borrow  <= 1'b0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_a_sh    <= A_i;
            r_b_sh    <= B_i;
            r_signed  <= signed_i;
            r_borrow  <= 1'b0;
            r_zero    <= 1'b1;
            r_cnt     <= '0;
        end else if (r_state == BUSY) begin
            r_a_sh    <= r_a_sh >> CHUNK;
            r_b_sh    <= r_b_sh >> CHUNK;
            r_borrow  <= w_borrow_out;
            r_zero    <= r_zero & w_chunk_zero;
            if (w_last) begin
                r_cnt     <= '0;
                r_equal   <= (w_result == RES_EQ);
                r_greater <= (w_result == RES_GT);
                r_lesser  <= (w_result == RES_LT);
            end else begin
                r_cnt     <= r_cnt + CW'(1);
            end
        end
    end

    assign ready_o   = (r_state != BUSY);
    assign done_o    = (r_state == DONE);
    assign equal_o   = r_equal;
    assign greater_o = r_greater;
    assign lesser_o  = r_lesser;

endmodule

`default_nettype wire
